// File: rtl/bias_ram_server.sv
// bias_ram_server: packs 64-bit load beats into 512-bit bias words and serves xpe reads with 2-cycle latency.
// Optional macro BIAS_RAM_FWD_EN: a read that coincides with a commit to the same address returns the new word.
module bias_ram_server #(
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int LOAD_WIDTH     = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_load_start,
    input  logic [RAM_ADDR_WIDTH-1:0] i_load_addr,
    input  logic [RAM_ADDR_WIDTH:0]   i_load_words,
    input  logic [LOAD_WIDTH-1:0]     i_load_dat,
    input  logic                      i_load_vld,
    output logic                      o_load_rdy,
    output logic                      o_load_done,
    output logic                      o_busy,
    input  logic                      i_ram_rd_en,
    input  logic [RAM_ADDR_WIDTH-1:0] i_ram_addr,
    output logic [511:0]              o_ram_dat,
    output logic                      o_ram_dat_vld
);

    // state   | meaning
    // IDLE    | waiting for i_load_start
    // LOAD    | accepting beats, committing a word every BEATS beats
    // DONE    | one-cycle o_load_done pulse, then back to IDLE

    localparam int WORD_W = 512;
    localparam int BEATS  = WORD_W / LOAD_WIDTH;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int WCNT_W = RAM_ADDR_WIDTH + 1;
    localparam int PACK_W = WORD_W - LOAD_WIDTH;
    localparam int DEPTH  = 1 << RAM_ADDR_WIDTH;

    localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0]         BEAT_ONE  = BEAT_W'(1);
    localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_ONE  = RAM_ADDR_WIDTH'(1);
    localparam logic [WCNT_W-1:0]         WORDS_ONE = WCNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_q;
    logic [BEAT_W-1:0]         beat_cnt_q;
    logic [RAM_ADDR_WIDTH-1:0] wr_addr_q;
    logic [WCNT_W-1:0]         words_left_q;
    logic [PACK_W-1:0]         pack_q;
    logic                      load_rdy_q;
    logic                      load_done_q;
    logic                      busy_q;

    logic [WORD_W-1:0]         mem [DEPTH];

    logic                      beat_acc;
    logic                      commit_en;
    logic [WORD_W-1:0]         commit_word_d;
    logic [WORD_W-1:0]         rd_word_d;

    logic                      rd1_vld_q;
    logic [WORD_W-1:0]         rd1_dat_q;
    logic                      ram_dat_vld_q;
    logic [WORD_W-1:0]         ram_dat_q;

    always_comb begin
        beat_acc      = i_load_vld && load_rdy_q;
        commit_en     = beat_acc && (beat_cnt_q == LAST_BEAT);
        commit_word_d = {i_load_dat, pack_q};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            wr_addr_q    <= '0;
            words_left_q <= '0;
            pack_q       <= '0;
            load_rdy_q   <= 1'b0;
            load_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_load_start) begin
                        wr_addr_q    <= i_load_addr;
                        words_left_q <= i_load_words;
                        beat_cnt_q   <= '0;
                        busy_q       <= 1'b1;
                        if (i_load_words == '0) begin
                            state_q     <= ST_DONE;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q    <= ST_LOAD;
                            load_rdy_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (commit_en) begin
                        beat_cnt_q   <= '0;
                        wr_addr_q    <= wr_addr_q + ADDR_ONE;
                        words_left_q <= words_left_q - WORDS_ONE;
                        if (words_left_q == WORDS_ONE) begin
                            state_q     <= ST_DONE;
                            load_rdy_q  <= 1'b0;
                            load_done_q <= 1'b1;
                        end
                    end else if (beat_acc) begin
                        for (int b = 0; b < BEATS - 1; b++) begin
                            if (beat_cnt_q == BEAT_W'(b)) begin
                                pack_q[b*LOAD_WIDTH +: LOAD_WIDTH] <= i_load_dat;
                            end
                        end
                        beat_cnt_q <= beat_cnt_q + BEAT_ONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    load_rdy_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Storage is intentionally not reset; contents are undefined until loaded.
    always_ff @(posedge i_clk) begin
        if (commit_en) begin
            mem[wr_addr_q] <= commit_word_d;
        end
    end

    always_comb begin
`ifdef BIAS_RAM_FWD_EN
        if (commit_en && (wr_addr_q == i_ram_addr)) begin
            rd_word_d = commit_word_d;
        end else begin
            rd_word_d = mem[i_ram_addr];
        end
`else
        rd_word_d = mem[i_ram_addr];
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd1_vld_q     <= 1'b0;
            rd1_dat_q     <= '0;
            ram_dat_vld_q <= 1'b0;
            ram_dat_q     <= '0;
        end else begin
            rd1_vld_q <= i_ram_rd_en;
            if (i_ram_rd_en) begin
                rd1_dat_q <= rd_word_d;
            end
            ram_dat_vld_q <= rd1_vld_q;
            if (rd1_vld_q) begin
                ram_dat_q <= rd1_dat_q;
            end
        end
    end

    assign o_load_rdy    = load_rdy_q;
    assign o_load_done   = load_done_q;
    assign o_busy        = busy_q;
    assign o_ram_dat     = ram_dat_q;
    assign o_ram_dat_vld = ram_dat_vld_q;

endmodule
